mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the core's data-store bus, in parallel with the data memory. Snoops memwrite / dataaddr / writedata from the single-cycle core top level, captures stores to its transmit address into a small FIFO, and serializes each byte as an 8N1 frame on tx. The core has no stall input, so stores are never back-pressured: a store to a full FIFO is dropped and flagged.

## Interface
- WIDTH, 32, data/address bus width (matches core)
- TXADDR, 32'hFFFF_FF00, store address that pushes writedata[7:0] into the FIFO
- CTRLADDR, 32'hFFFF_FF04, store address for control; writedata[0]=1 clears overflow
- DEPTH, 8, FIFO entries; power of 2, ≥2
- CLKDIV, 16, clock cycles per serial bit; ≥2
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- memwrite  input  1  store strobe from core
- dataaddr  input  WIDTH  store address (full-width compare, no masking)
- writedata  input  WIDTH  store data
- tx  output  1  serial line, idle high
- busy  output  1  high while a frame is in flight or FIFO non-empty
- overflow  output  1  sticky: a TXADDR store was dropped
- level  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset (async assert, sync-release to the clock edge): tx=1, busy=0, overflow=0, level=0, FIFO pointers 0, FSM=IDLE, bit/divider counters 0.
- Push: memwrite && dataaddr==TXADDR at a rising edge → writedata[7:0] written at write pointer if level<DEPTH; else dropped and overflow set.
- Control: memwrite && dataaddr==CTRLADDR && writedata[0] → overflow cleared. Same-edge drop and clear: set wins.
- Stores to any other address are ignored.
- FIFO: circular, pointers wrap modulo DEPTH; level = pushes − pops. Simultaneous push and pop at level==DEPTH: pop frees the slot, push accepted, level stays DEPTH. At level==0 no pop occurs.
- FSM states: IDLE, START, DATA, STOP (+PARITY when configured).
  - IDLE: tx=1. If level>0 at an edge, pop head into shift register, go START.
  - START: tx=0 for CLKDIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first; each CLKDIV cycles shift right, index+1; after index 7 completes go STOP (or PARITY).
  - STOP: tx=1 for CLKDIV cycles. At the final cycle: if level>0 pop and go START (back-to-back, no idle gap), else IDLE.
- Divider counts 0..CLKDIV−1 and restarts on every state change.
- busy = (FSM≠IDLE) || (level>0).
- Reset mid-frame: frame aborted, tx returns high immediately, FIFO contents discarded.

## Timing
- tx is a registered output; no combinational path from any input to any output.
- Store at edge N into empty FIFO, FSM IDLE: level=1 after N; pop at N+1 (level back to 0, tx=0 after N+1).
- Frame length 10×CLKDIV cycles (11×CLKDIV with parity); start bit occupies edges N+1..N+CLKDIV.
- Back-to-back frames: start bit of next frame begins the cycle after the last stop-bit cycle.
- overflow visible the cycle after the offending edge; level updates same edge as push/pop.

## Configuration
- MMIO_UART_PARITY_EN defined: PARITY state inserted between DATA and STOP, tx = XOR of the 8 data bits (even parity) for CLKDIV cycles; frame 11×CLKDIV.
- Undefined: no PARITY state, 8N1, frame 10×CLKDIV. Port list identical in both builds.

## Test plan
- Reset: assert rst mid-frame → tx=1, busy=0, level=0, overflow=0 asynchronously, before the next edge.
- Single byte: CLKDIV=4, store 0x000000A5 to TXADDR → tx low 1 cycle later for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; busy drops after 40 cycles.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles → two contiguous frames, no idle gap, level peaks at 1.
- Overflow: DEPTH=8, 10 consecutive TXADDR stores during first frame → level=8, overflow=1, bytes 10 dropped; store 1 to CTRLADDR → overflow=0.
- Full with simultaneous pop: level=8 and store on the edge the STOP state pops → push accepted, level stays 8, overflow stays 0.
- Parity build: store 0x07 → parity bit 1 after data; store 0x03 → parity bit 0; frame 11×CLKDIV.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped UART transmitter snooping the core's store bus. Stores to
// TXADDR push writedata[7:0] into a circular FIFO; the FSM drains the FIFO
// as 8N1 frames on tx (LSB first). The core cannot stall, so a store to a
// full FIFO is dropped and recorded in the sticky overflow flag. A store to
// CTRLADDR with writedata[0]=1 clears overflow.
//
// Build option: define MMIO_UART_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame becomes 11 bit times).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   memwrite  in   store strobe from the core
//   dataaddr  in   store address (full-width compare)
//   writedata in   store data
//   tx        out  registered serial line, idle high
//   busy      out  frame in flight or FIFO non-empty
//   overflow  out  sticky: a TXADDR store was dropped
//   level     out  current FIFO occupancy
//
// Handshake: there is none on the bus side. A qualifying store is sampled on
// the rising edge where memwrite is high; it is either accepted or dropped
// in that same edge, never held off.
module mmio_uart_tx #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  TXADDR   = 32'hFFFF_FF00,
  parameter logic [WIDTH-1:0]  CTRLADDR = 32'hFFFF_FF04,
  parameter int                DEPTH    = 8,
  parameter int                CLKDIV   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memwrite,
  input  logic [WIDTH-1:0]         dataaddr,
  input  logic [WIDTH-1:0]         writedata,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = $clog2(CLKDIV);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
`ifdef MMIO_UART_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            push_req, clr_req, push_ok, pop, div_done, have_data;
  logic [7:0]      head;
  logic            unused_wdata;

  assign unused_wdata = ^writedata[WIDTH-1:8];
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    push_req   = memwrite && (dataaddr == TXADDR);
    clr_req    = memwrite && (dataaddr == CTRLADDR) && writedata[0];
    have_data  = (level_q != '0);
    div_done   = (div_q == DIV_LAST);
    pop        = 1'b0;
    state_d    = state_q;
    div_d      = div_q + DW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
`ifdef MMIO_UART_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (have_data) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_done) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (div_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: begin
        if (div_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Last stop cycle: pop straight into the next start bit so
        // back-to-back frames have no idle gap.
        if (div_done) begin
          if (have_data) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bit timing restarts on every state change.
    if (state_d != state_q) div_d = '0;

    if (pop) begin
      shift_d = head;
`ifdef MMIO_UART_PARITY_EN
      parity_d = ^head;
`endif
    end

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    push_ok  = push_req && ((level_q != DEPTH_L) || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = writedata[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Set beats clear when both happen on one edge.
    overflow_d = overflow_q;
    if (clr_req) overflow_d = 1'b0;
    if (push_req && !push_ok) overflow_d = 1'b1;

    // tx is registered from the next state so it changes with the state.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
      mem_q      <= '{default: '0};
`ifdef MMIO_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
      mem_q      <= mem_d;
`ifdef MMIO_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKDIV=4, DEPTH=8. A table of single-byte
// frames is checked cycle by cycle; hand-written sequences cover
// back-to-back frames, overflow/clear, full FIFO with simultaneous pop and
// asynchronous reset mid-frame. A serial monitor decodes every frame on tx
// and compares it with the expected queue filled when stores are driven.
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 8;
`ifdef MMIO_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;
  localparam logic [31:0] TXA   = 32'hFFFF_FF00;
  localparam logic [31:0] CTRLA = 32'hFFFF_FF04;

  logic        clk, rst, memwrite;
  logic [31:0] dataaddr, writedata;
  logic        tx, busy, overflow;
  logic [3:0]  level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_epoch = 0;
  logic [8:0] exp_q[$];   // {parity, data}

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  mmio_uart_tx #(
    .WIDTH(32), .TXADDR(TXA), .CTRLADDR(CTRLA), .DEPTH(D), .CLKDIV(C)
  ) dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataaddr(dataaddr),
    .writedata(writedata), .tx(tx), .busy(busy), .overflow(overflow),
    .level(level)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(400000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    dataaddr  = a;
    writedata = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    memwrite  = 1'b0;
    dataaddr  = '0;
    writedata = '0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    bus_write(TXA, {24'h0, d});
    exp_q.push_back({^d, d});
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  function automatic logic exp_tx(input int k, input logic [7:0] d, input logic p);
    if (k <= C) return 1'b0;
    if (k <= 9 * C) return d[(k - C - 1) / C];
`ifdef MMIO_UART_PARITY_EN
    if (k <= 10 * C) return p;
`endif
    return 1'b1;
  endfunction

  // Called at the negedge right after the store edge N; k counts edges after N.
  task automatic check_frame(input logic [7:0] d, input logic p);
    check("level_after_push", level, 1);
    check("busy_after_push", busy, 1);
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clk);
      check($sformatf("frame_tx d=%0h k=%0d", d, k), tx, exp_tx(k, d, p));
      if (k == 1)      check("level_after_pop", level, 0);
      if (k == FL)     check("busy_last_stop", busy, 1);
      if (k == FL + 1) check("busy_after_frame", busy, 0);
    end
  endtask

  // scoreboard: serial monitor
  initial begin : monitor
    int         ep;
    logic [7:0] d;
    logic       p;
    logic       sb;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        ep = rst_epoch;
        p  = 1'b0;
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          d[i] = tx;
        end
`ifdef MMIO_UART_PARITY_EN
        repeat (C) @(negedge clk);
        p = tx;
`endif
        repeat (C) @(negedge clk);
        sb = tx;
        if (ep == rst_epoch) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mon_unexpected_frame: actual=%0h required=none", d);
          end else begin
            e = exp_q.pop_front();
            check("mon_data", d, e[7:0]);
`ifdef MMIO_UART_PARITY_EN
            check("mon_parity", p, e[8]);
`endif
            check("mon_stop", sb, 1);
          end
        end
      end
    end
  end

  // stimulus
  initial begin : main
    int   n0, pop_edge, mx;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h00, 1'b0};
    vecs[7] = '{8'h3C, 1'b0};

    rst = 1'b1; memwrite = 1'b0; dataaddr = '0; writedata = '0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);

    // table of single-byte frames
    for (int i = 0; i < 8; i++) begin
      push_tx(vecs[i].data);
      bus_idle();
      check_frame(vecs[i].data, vecs[i].par);
    end

    // back-to-back: two consecutive stores, contiguous frames
    push_tx(8'h55);
    push_tx(8'h0F);
    bus_idle();
    check("b2b_level_k1", level, 1);
    check("b2b_start_k1", tx, 0);
    mx = int'(level);
    for (int k = 2; k <= 2 * FL + 1; k++) begin
      @(negedge clk);
      if (int'(level) > mx) mx = int'(level);
      if (k == FL)     check("b2b_last_stop", tx, 1);
      if (k == FL + 1) check("b2b_next_start", tx, 0);
      if (k == FL + 1) check("b2b_busy_gap", busy, 1);
      if (k == FL + 2) check("b2b_level_drained", level, 0);
    end
    check("b2b_level_peak", mx, 1);
    wait_idle(20, "b2b_idle");

    // overflow: 10 consecutive stores; byte 1 transmits, 8 fill the FIFO,
    // byte 10 is dropped
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      bus_write(TXA, {24'h0, d});
      if (i == 0) n0 = cyc + 1;
      if (i < 9) exp_q.push_back({^d, d});
    end
    bus_idle();
    check("ovf_level_full", level, 8);
    check("ovf_flag_set", overflow, 1);
    bus_write(CTRLA, 32'h0000_0002);
    bus_idle();
    check("ovf_ctrl_bit0_zero", overflow, 1);
    bus_write(CTRLA, 32'h0000_0001);
    bus_idle();
    check("ovf_cleared", overflow, 0);
    check("ovf_level_after_clr", level, 8);
    bus_write(32'hFFFF_FF08, 32'h0000_0012);
    bus_idle();
    check("other_addr_level", level, 8);
    check("other_addr_ovf", overflow, 0);

    // full FIFO, store on the edge the STOP state pops
    pop_edge = n0 + FL + 1;
    while (cyc < pop_edge - 2) @(negedge clk);
    d = 8'($urandom_range(0, 255));
    push_tx(d);
    bus_idle();
    check("full_pop_level", level, 8);
    check("full_pop_ovf", overflow, 0);
    wait_idle(12 * FL, "drain_idle");
    check("drain_queue_empty", exp_q.size(), 0);

    // asynchronous reset in the middle of an all-zero frame
    for (int i = 0; i < 10; i++) bus_write(TXA, 32'h0);
    bus_idle();
    check("pre_rst_tx_low", tx, 0);
    check("pre_rst_ovf", overflow, 1);
    check("pre_rst_level", level, 8);
    @(negedge clk);
    #2;
    rst = 1'b1;
    rst_epoch++;
    exp_q.delete();
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_level", level, 0);
    check("async_rst_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("after_rst_tx_idle", tx, 1);
    check("after_rst_busy", busy, 0);
    check("after_rst_level", level, 0);

    // one more frame to show the FIFO restarts cleanly after reset
    push_tx(8'hC3);
    bus_idle();
    check_frame(8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
